// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int UART_BIT_TICKS_115200 = 286;
  localparam int UART_DATA_BITS        = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign do_pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push  = wr_en && (!full || do_pop);
  assign overflow = wr_en && full && !do_pop;
  assign count    = count_reg;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with sticky line-error flags feeding a show-ahead FIFO.
// Define UART_RX_GLITCH_FILTER_EN for 3-sample majority voting around each bit centre.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BIT_TICKS  = UART_BIT_TICKS_115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          lpc_clk,
  input  logic                          lpc_rst,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          framing_err,
  output logic                          overrun_err
);
  localparam int CNT_W = $clog2(BIT_TICKS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_TICKS - 1);

  rx_state_t                 state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [2:0]                bit_reg, bit_next;
  logic [UART_DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                      sync1_reg, rx_s;
  logic                      expiry, sample_valid, sample_bit;
  logic                      push, frame_set, overflow;
  logic                      framing_err_reg, overrun_err_reg;

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= uart_rx;
      rx_s      <= sync1_reg;
    end
  end

  assign expiry = (state_reg inside {START, DATA, STOP}) && (cnt_reg == '0);

`ifdef UART_RX_GLITCH_FILTER_EN
  // Decide one cycle late so the vote can include the sample after expiry.
  logic rx_d1_reg, rx_d2_reg, pend_reg;
  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      rx_d1_reg <= 1'b1;
      rx_d2_reg <= 1'b1;
      pend_reg  <= 1'b0;
    end else begin
      rx_d1_reg <= rx_s;
      rx_d2_reg <= rx_d1_reg;
      pend_reg  <= expiry;
    end
  end
  assign sample_valid = pend_reg;
  assign sample_bit   = (rx_s & rx_d1_reg) | (rx_s & rx_d2_reg) | (rx_d1_reg & rx_d2_reg);
`else
  assign sample_valid = expiry;
  assign sample_bit   = rx_s;
`endif

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    push       = 1'b0;
    frame_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (sample_valid) begin
          state_next = sample_bit ? IDLE : DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (sample_valid) begin
          shreg_next = {sample_bit, shreg_reg[UART_DATA_BITS-1:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'(UART_DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop lets a start edge in the second half be caught.
        if (sample_valid) begin
          if (sample_bit) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE) begin
      if (expiry)             cnt_next = FULL_LOAD;
      else if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge lpc_clk or negedge lpc_rst) begin
    if (!lpc_rst) begin
      framing_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      if (frame_set)    framing_err_reg <= 1'b1;
      else if (err_clr) framing_err_reg <= 1'b0;
      if (overflow)     overrun_err_reg <= 1'b1;
      else if (err_clr) overrun_err_reg <= 1'b0;
    end
  end

  assign framing_err = framing_err_reg;
  assign overrun_err = overrun_err_reg;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (lpc_clk),
    .rst_n    (lpc_rst),
    .wr_en    (push),
    .wr_data  (shreg_reg),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (rx_count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int BT    = 286;
  localparam int DEPTH = 16;

  logic       lpc_clk;
  logic       lpc_rst;
  logic       uart_rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic [4:0] rx_count;
  logic       framing_err;
  logic       overrun_err;

  uart_rx_fifo dut (
    .lpc_clk     (lpc_clk),
    .lpc_rst     (lpc_rst),
    .uart_rx     (uart_rx),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rd_data     (rd_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .rx_count    (rx_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  initial lpc_clk = 1'b0;
  always #5 lpc_clk = ~lpc_clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mq[$];
  logic       m_fe = 1'b0;
  logic       m_oe = 1'b0;

  task automatic tick();
    @(posedge lpc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(rx_count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(rx_empty), 32'(mq.size() == 0));
    check({tag, ".full"}, 32'(rx_full), 32'(mq.size() == DEPTH));
    if (mq.size() > 0) check({tag, ".head"}, 32'(rd_data), 32'(mq[0]));
    check({tag, ".framing_err"}, 32'(framing_err), 32'(m_fe));
    check({tag, ".overrun_err"}, 32'(overrun_err), 32'(m_oe));
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_oe = 1'b1;
  endfunction

  // Drives one frame; rd_en is pulsed on tick pop_at, push_t is the tick where rx_count changed.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at,
                            output int push_t);
    logic [9:0] bits;
    logic [4:0] prev;
    bits   = {stop_bit, b, 1'b0};
    prev   = rx_count;
    push_t = -1;
    for (int t = 0; t < 10 * BT; t++) begin
      uart_rx = bits[t / BT];
      rd_en   = (t == pop_at);
      tick();
      if (push_t < 0 && rx_count != prev) push_t = t;
    end
    rd_en = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    check_state(tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    check_state({tag, ".after"});
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int         pt;
    int         lat;
    logic [7:0] b;
    logic [9:0] part;

    lpc_rst = 1'b0;
    uart_rx = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();
    check_state("reset");
    check("reset.rd_data", 32'(rd_data), 32'h0);
    lpc_rst = 1'b1;
    idle(20);

    // back-to-back 0x0f, 0xa5
    send_frame(8'h0f, 1'b1, -1, pt); m_push(8'h0f);
    send_frame(8'ha5, 1'b1, -1, pt); m_push(8'ha5);
    idle(20);
    check_state("b2b");
    pop_one("b2b.pop0");
    pop_one("b2b.pop1");
    pop_one("empty_pop");

    // false start
    uart_rx = 1'b0;
    repeat (100) tick();
    idle(600);
    check_state("false_start");

    // framing error then break, then a good frame
    send_frame(8'hf3, 1'b0, -1, pt);
    m_fe = 1'b1;
    uart_rx = 1'b0;
    repeat (500) tick();
    check_state("framing");
    idle(50);
    send_frame(8'hf4, 1'b1, -1, pt); m_push(8'hf4);
    idle(20);
    check_state("after_break");
    pop_one("after_break.pop");
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_fe = 1'b0;
    check_state("err_clr");

    // random bytes with random idle gaps
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      idle($urandom_range(0, 40));
      send_frame(b, 1'b1, -1, pt); m_push(b);
    end
    idle(20);
    check_state("rand");
    while (mq.size() > 0) pop_one("rand.pop");

    // fill to 16, then one more for overrun
    lat = -1;
    for (int i = 0; i < 17; i++) begin
      b = 8'(8'hf0 + i);
      send_frame(b, 1'b1, -1, pt);
      m_push(b);
      if (i == 15) lat = pt;
    end
    idle(20);
    check_state("overrun");
    checks++;
    assert (lat >= 2715 && lat <= 2722) else begin
      errors++;
      $error("FAIL push_latency observed=%0d expected=2715..2722", lat);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_oe = 1'b0;

    // push coincident with pop while full
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, lat, pt);
    void'(mq.pop_front());
    mq.push_back(b);
    idle(20);
    check_state("full_pushpop");
    for (int i = 0; i < 15; i++) pop_one("drain");
    check("tail", 32'(rd_data), 32'(b));

    // reset during data bit 4 of 0xa5
    part = {1'b1, 8'ha5, 1'b0};
    for (int t = 0; t < 5 * BT + 100; t++) begin
      uart_rx = part[t / BT];
      tick();
    end
    lpc_rst = 1'b0;
    #1;
    mq.delete();
    m_fe = 1'b0;
    m_oe = 1'b0;
    check_state("rst_async");
    check("rst_async.rd_data", 32'(rd_data), 32'h0);
    uart_rx = 1'b1;
    repeat (10) tick();
    check_state("rst_hold");
    lpc_rst = 1'b1;
    idle(5);
    send_frame(8'hf5, 1'b1, -1, pt); m_push(8'hf5);
    idle(20);
    check_state("after_rst");
    pop_one("after_rst.pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
